// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_dbg_pkg
//  Description : Shared encodings for the mips run-control / debug path:
//                monitor command opcodes, halt-cause codes, sequencer state
//                enum and the architectural register count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_dbg_pkg;

   // Monitor command opcodes (3-bit field); 5..7 are illegal
   localparam logic [2:0] C_OP_HALT  = 3'd0;
   localparam logic [2:0] C_OP_RUN   = 3'd1;
   localparam logic [2:0] C_OP_STEP  = 3'd2;
   localparam logic [2:0] C_OP_RESET = 3'd3;
   localparam logic [2:0] C_OP_DUMP  = 3'd4;

   // Reason the core last entered the halted state
   localparam logic [1:0] C_CAUSE_CMD  = 2'd0;
   localparam logic [1:0] C_CAUSE_BP   = 2'd1;
   localparam logic [1:0] C_CAUSE_STEP = 2'd2;
   localparam logic [1:0] C_CAUSE_RST  = 2'd3;

   // Number of general-purpose registers streamed by a dump
   localparam int NUM_REGS = 32;

   typedef enum logic [2:0] {
      ST_CRST = 3'd0,
      ST_HALT = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_DUMP = 3'd4
   } run_state_t;

endpackage : mips_dbg_pkg
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_ctrl
//  Description : Run-control sequencer for the single-cycle mips core.
//                Holds the core in reset, gates its clock enable for
//                halt/run/single-step with a PC breakpoint, and walks the
//                debug register-read port to stream all GPRs to the monitor.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                cmd_*             - monitor command handshake (op, steps)
//                bp_en, bp_addr    - PC breakpoint
//                pc                - current core PC
//                cpu_en, cpu_rst   - core clock enable / core reset
//                dbg_ra, dbg_rd    - core debug register read port
//                dump_*            - register dump stream to the monitor
//                halted, halt_cause, instr_count, cmd_err - status
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_run_ctrl
   import mips_dbg_pkg::*;
#(
   parameter int RST_CYCLES = 2,
   parameter int STEP_W     = 16,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              bp_en,
   input  logic [31:0]       bp_addr,
   input  logic [31:0]       pc,
   output logic              cpu_en,
   output logic              cpu_rst,
   output logic [4:0]        dbg_ra,
   input  logic [31:0]       dbg_rd,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [31:0]       dump_data,
   output logic [4:0]        dump_idx,
   output logic              dump_last,
   output logic              halted,
   output logic [1:0]        halt_cause,
   output logic [CNT_W-1:0]  instr_count,
   output logic              cmd_err
);

   localparam int          RC_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] C_RST_INIT = RC_W'(RST_CYCLES - 1);
   localparam logic [4:0]  C_LAST_REG = 5'(NUM_REGS - 1);

   run_state_t        state_q, state_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [4:0]        dbg_ra_q, dbg_ra_d;
   logic [CNT_W-1:0]  instr_count_q, instr_count_d;
   logic [1:0]        halt_cause_q, halt_cause_d;
   logic              cmd_err_q, cmd_err_d;
   // High for the first cycle after leaving HALT into RUN/STEP so the core
   // can execute the instruction sitting on the breakpoint address.
   logic              first_q, first_d;

   logic              w_cmd_acc;
   logic              w_run_like;
   logic              w_bp_hit;
   logic              w_reset_cmd;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_CRST;
         rst_cnt_q     <= C_RST_INIT;
         step_cnt_q    <= '0;
         dbg_ra_q      <= '0;
         instr_count_q <= '0;
         halt_cause_q  <= C_CAUSE_RST;
         cmd_err_q     <= 1'b0;
         first_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         step_cnt_q    <= step_cnt_d;
         dbg_ra_q      <= dbg_ra_d;
         instr_count_q <= instr_count_d;
         halt_cause_q  <= halt_cause_d;
         cmd_err_q     <= cmd_err_d;
         first_q       <= first_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      step_cnt_d    = step_cnt_q;
      dbg_ra_d      = dbg_ra_q;
      instr_count_d = instr_count_q;
      halt_cause_d  = halt_cause_q;
      cmd_err_d     = cmd_err_q;
      first_d       = 1'b0;

      cmd_ready   = (state_q == ST_HALT) || (state_q == ST_RUN) || (state_q == ST_STEP);
      w_cmd_acc   = cmd_valid & cmd_ready;
      w_run_like  = (state_q == ST_RUN) || (state_q == ST_STEP);
      w_bp_hit    = w_run_like & bp_en & (pc == bp_addr) & ~first_q;
      w_reset_cmd = w_cmd_acc & (cmd_op == C_OP_RESET);
      // A RESET accepted while running must not let another instruction
      // retire; rst is folded in so nothing retires while the block resets.
      cpu_en      = w_run_like & ~w_bp_hit & ~w_reset_cmd & ~rst;

      if (cpu_en) begin
         instr_count_d = instr_count_q + CNT_W'(1);
      end

      case (state_q)
         ST_CRST: begin
            if (rst_cnt_q == '0) begin
               state_d      = ST_HALT;
               halt_cause_d = C_CAUSE_RST;
            end else begin
               rst_cnt_d = rst_cnt_q - RC_W'(1);
            end
         end

         ST_HALT: begin
            if (w_cmd_acc) begin
               case (cmd_op)
                  C_OP_HALT: ;
                  C_OP_RUN: begin
                     state_d = ST_RUN;
                     first_d = 1'b1;
                  end
                  C_OP_STEP: begin
                     state_d    = ST_STEP;
                     first_d    = 1'b1;
                     step_cnt_d = (cmd_steps == '0) ? STEP_W'(1) : cmd_steps;
                  end
                  C_OP_DUMP: begin
                     state_d  = ST_DUMP;
                     dbg_ra_d = '0;
                  end
                  C_OP_RESET: begin
                     state_d       = ST_CRST;
                     rst_cnt_d     = C_RST_INIT;
                     instr_count_d = '0;
                     cmd_err_d     = 1'b0;
                  end
                  default: cmd_err_d = 1'b1;
               endcase
            end
         end

         ST_RUN, ST_STEP: begin
            if (w_reset_cmd) begin
               state_d       = ST_CRST;
               rst_cnt_d     = C_RST_INIT;
               instr_count_d = '0;
               cmd_err_d     = 1'b0;
            end else begin
               if (w_cmd_acc && (cmd_op != C_OP_HALT)) begin
                  cmd_err_d = 1'b1;
               end
               if ((state_q == ST_STEP) && cpu_en) begin
                  step_cnt_d = step_cnt_q - STEP_W'(1);
               end
               // Breakpoint outranks both a HALT command and step completion
               if (w_bp_hit) begin
                  state_d      = ST_HALT;
                  halt_cause_d = C_CAUSE_BP;
               end else if (w_cmd_acc && (cmd_op == C_OP_HALT)) begin
                  state_d      = ST_HALT;
                  halt_cause_d = C_CAUSE_CMD;
               end else if ((state_q == ST_STEP) && cpu_en && (step_cnt_q == STEP_W'(1))) begin
                  state_d      = ST_HALT;
                  halt_cause_d = C_CAUSE_STEP;
               end
            end
         end

         ST_DUMP: begin
            if (dump_ready) begin
               if (dbg_ra_q == C_LAST_REG) begin
                  state_d  = ST_HALT;
                  dbg_ra_d = '0;
               end else begin
                  dbg_ra_d = dbg_ra_q + 5'd1;
               end
            end
         end

         default: state_d = ST_CRST;
      endcase
   end

   assign cpu_rst     = (state_q == ST_CRST);
   assign halted      = (state_q == ST_HALT);
   assign dbg_ra      = dbg_ra_q;
   assign dump_valid  = (state_q == ST_DUMP);
   assign dump_idx    = dbg_ra_q;
   assign dump_data   = dbg_rd;
   assign dump_last   = dump_valid & (dbg_ra_q == C_LAST_REG);
   assign halt_cause  = halt_cause_q;
   assign instr_count = instr_count_q;
   assign cmd_err     = cmd_err_q;

endmodule : mips_run_ctrl
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_run_ctrl
//  Description : Self-checking bench for mips_run_ctrl. A behavioural model
//                of the run-control rules is compared against the DUT every
//                cycle; directed sequences add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_run_ctrl;

   localparam int RST_CYCLES = 2;
   localparam int STEP_W     = 16;
   localparam int CNT_W      = 32;

   // model modes
   localparam int M_RST  = 0;
   localparam int M_HALT = 1;
   localparam int M_RUN  = 2;
   localparam int M_STEP = 3;
   localparam int M_DUMP = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [2:0]        cmd_op = 3'd0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic              bp_en = 1'b0;
   logic [31:0]       bp_addr = 32'h0;
   logic [31:0]       pc = 32'h0;
   logic              cpu_en;
   logic              cpu_rst;
   logic [4:0]        dbg_ra;
   logic [31:0]       dbg_rd;
   logic              dump_valid;
   logic              dump_ready = 1'b0;
   logic [31:0]       dump_data;
   logic [4:0]        dump_idx;
   logic              dump_last;
   logic              halted;
   logic [1:0]        halt_cause;
   logic [CNT_W-1:0]  instr_count;
   logic              cmd_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Register file contents seen through the debug read port
   function automatic logic [31:0] reg_val(input logic [4:0] idx);
      return 32'hC0DE_0000 | (32'(idx) * 32'h0101);
   endfunction

   assign dbg_rd = reg_val(dbg_ra);

   mips_run_ctrl #(
      .RST_CYCLES (RST_CYCLES),
      .STEP_W     (STEP_W),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_steps   (cmd_steps),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .pc          (pc),
      .cpu_en      (cpu_en),
      .cpu_rst     (cpu_rst),
      .dbg_ra      (dbg_ra),
      .dbg_rd      (dbg_rd),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_data   (dump_data),
      .dump_idx    (dump_idx),
      .dump_last   (dump_last),
      .halted      (halted),
      .halt_cause  (halt_cause),
      .instr_count (instr_count),
      .cmd_err     (cmd_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model + per-cycle compare (mid-cycle, inputs stable)
   // ---------------------------------------------------------------------
   bit          m_init = 0;
   int          m_mode = M_RST;
   int          m_rst_left = 0;   // reset cycles still to be spent
   int          m_steps_left = 0; // instructions still to retire in STEP
   int          m_idx = 0;        // next register to stream
   logic [31:0] m_cnt = '0;
   int          m_cause = 3;
   bit          m_err = 0;
   bit          m_fresh = 0;      // just left HALT: breakpoint ignored
   bit          e_running, e_bp, e_ready, e_acc, e_en, e_dv;

   always @(negedge clk) begin
      e_running = (m_mode == M_RUN) || (m_mode == M_STEP);
      e_bp      = e_running && bp_en && (pc == bp_addr) && !m_fresh;
      e_ready   = (m_mode == M_HALT) || e_running;
      e_acc     = cmd_valid && e_ready;
      e_en      = e_running && !e_bp && !(e_acc && cmd_op == 3'd3) && !rst;
      e_dv      = (m_mode == M_DUMP);

      if (m_init) begin
         chk("cpu_en",      32'(cpu_en),      32'(e_en));
         chk("cpu_rst",     32'(cpu_rst),     32'(m_mode == M_RST));
         chk("halted",      32'(halted),      32'(m_mode == M_HALT));
         chk("cmd_ready",   32'(cmd_ready),   32'(e_ready));
         chk("dump_valid",  32'(dump_valid),  32'(e_dv));
         chk("dump_last",   32'(dump_last),   32'(e_dv && m_idx == 31));
         chk("dbg_ra",      32'(dbg_ra),      32'(m_idx));
         chk("halt_cause",  32'(halt_cause),  32'(m_cause));
         chk("cmd_err",     32'(cmd_err),     32'(m_err));
         chk("instr_count", instr_count,      m_cnt);
         if (e_dv) begin
            chk("dump_idx",  32'(dump_idx), 32'(m_idx));
            chk("dump_data", dump_data,     reg_val(5'(m_idx)));
         end
      end

      if (rst) begin
         m_init = 1; m_mode = M_RST; m_rst_left = RST_CYCLES;
         m_cnt = '0; m_cause = 3; m_err = 0; m_idx = 0; m_fresh = 0;
      end else if (m_init) begin
         if (e_en) m_cnt = m_cnt + 1;
         case (m_mode)
            M_RST: begin
               m_rst_left--;
               if (m_rst_left == 0) begin m_mode = M_HALT; m_cause = 3; end
            end
            M_HALT: if (e_acc) begin
               if (cmd_op == 3'd1) begin m_mode = M_RUN; m_fresh = 1; end
               else if (cmd_op == 3'd2) begin
                  m_mode = M_STEP; m_fresh = 1;
                  m_steps_left = (cmd_steps == 0) ? 1 : int'(cmd_steps);
               end
               else if (cmd_op == 3'd4) begin m_mode = M_DUMP; m_idx = 0; end
               else if (cmd_op == 3'd3) begin
                  m_mode = M_RST; m_rst_left = RST_CYCLES; m_cnt = '0; m_err = 0;
               end
               else if (cmd_op != 3'd0) m_err = 1;
            end
            M_RUN, M_STEP: begin
               m_fresh = 0;
               if (e_acc && cmd_op == 3'd3) begin
                  m_mode = M_RST; m_rst_left = RST_CYCLES; m_cnt = '0; m_err = 0;
               end else begin
                  if (e_acc && cmd_op != 3'd0) m_err = 1;
                  if (m_mode == M_STEP && e_en) m_steps_left--;
                  if (e_bp) begin m_mode = M_HALT; m_cause = 1; end
                  else if (e_acc && cmd_op == 3'd0) begin m_mode = M_HALT; m_cause = 0; end
                  else if (m_mode == M_STEP && e_en && m_steps_left == 0) begin
                     m_mode = M_HALT; m_cause = 2;
                  end
               end
            end
            M_DUMP: if (dump_ready) begin
               if (m_idx == 31) begin m_mode = M_HALT; m_idx = 0; end
               else m_idx++;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus. tick() also plays the core: PC clears in reset and advances
   // by 4 on every enabled cycle.
   // ---------------------------------------------------------------------
   task automatic tick();
      logic en_s, rst_s;
      @(negedge clk);
      en_s  = cpu_en;
      rst_s = cpu_rst;
      @(posedge clk);
      #1;
      if (rst_s === 1'b1)     pc = 32'h0;
      else if (en_s === 1'b1) pc = pc + 32'd4;
   endtask

   task automatic send(input logic [2:0] op, input logic [STEP_W-1:0] steps);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_steps = steps;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_halted(input string name, input int budget);
      int n = 0;
      while (halted !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(name, 32'(halted), 32'd1);
   endtask

   initial begin
      int words;
      int n;

      // reset: cpu_rst stays up exactly RST_CYCLES cycles after release
      tick();
      tick();
      rst = 1'b0;
      chk("lit_rst_c1", 32'(cpu_rst), 32'd1);
      tick();
      chk("lit_rst_c2", 32'(cpu_rst), 32'd1);
      tick();
      chk("lit_rst_done", 32'(cpu_rst), 32'd0);
      chk("lit_halted", 32'(halted), 32'd1);
      chk("lit_cause_rst", 32'(halt_cause), 32'd3);
      chk("lit_cnt0", instr_count, 32'd0);
      chk("lit_err0", 32'(cmd_err), 32'd0);

      // STEP 3, then STEP 0 (treated as 1)
      send(3'd2, 16'd3);
      wait_halted("step3_halt", 20);
      chk("lit_step3_cnt", instr_count, 32'd3);
      chk("lit_step3_cause", 32'(halt_cause), 32'd2);
      send(3'd2, 16'd0);
      wait_halted("step0_halt", 20);
      chk("lit_step0_cnt", instr_count, 32'd4);

      // RESET command returns PC to 0; then run into breakpoint at 0x10
      send(3'd3, 16'd0);
      wait_halted("reset_halt", 20);
      chk("lit_reset_cnt", instr_count, 32'd0);
      bp_en   = 1'b1;
      bp_addr = 32'h10;
      send(3'd1, 16'd0);
      wait_halted("bp_halt", 50);
      chk("lit_bp_cause", 32'(halt_cause), 32'd1);
      chk("lit_bp_cnt", instr_count, 32'd4);
      chk("lit_bp_pc", pc, 32'h10);
      send(3'd2, 16'd1);
      wait_halted("bp_step_halt", 20);
      chk("lit_bp_step_cnt", instr_count, 32'd5);
      chk("lit_bp_step_pc", pc, 32'h14);
      chk("lit_bp_step_cause", 32'(halt_cause), 32'd2);

      // DUMP with toggling ready
      words = 0;
      send(3'd4, 16'd0);
      n = 0;
      while (halted !== 1'b1 && n < 200) begin
         dump_ready = ~dump_ready;
         if (dump_valid === 1'b1 && dump_ready) words++;
         tick();
         n++;
      end
      dump_ready = 1'b0;
      chk("lit_dump_words", 32'(words), 32'd32);
      chk("lit_dump_halted", 32'(halted), 32'd1);

      // commands during RUN
      bp_en = 1'b0;
      send(3'd1, 16'd0);
      tick();
      send(3'd2, 16'd5);
      chk("lit_run_err", 32'(cmd_err), 32'd1);
      tick();
      chk("lit_still_running", 32'(halted), 32'd0);
      send(3'd3, 16'd0);
      chk("lit_run_reset_rst", 32'(cpu_rst), 32'd1);
      wait_halted("run_reset_halt", 20);
      chk("lit_run_reset_cnt", instr_count, 32'd0);
      chk("lit_run_reset_err", 32'(cmd_err), 32'd0);

      // plain HALT command during RUN
      send(3'd1, 16'd0);
      tick();
      tick();
      send(3'd0, 16'd0);
      chk("lit_cmd_halt", 32'(halted), 32'd1);
      chk("lit_cmd_cause", 32'(halt_cause), 32'd0);

      // illegal op in HALT
      send(3'd6, 16'd0);
      chk("lit_illegal_err", 32'(cmd_err), 32'd1);

      // HALT command in the same cycle as breakpoint hit
      send(3'd3, 16'd0);
      wait_halted("pre_bp_reset", 20);
      bp_en   = 1'b1;
      bp_addr = 32'h10;
      send(3'd1, 16'd0);
      n = 0;
      while (pc != 32'h10 && n < 20) begin
         tick();
         n++;
      end
      chk("bp_reach", pc, 32'h10);
      send(3'd0, 16'd0);
      chk("lit_both_halt", 32'(halted), 32'd1);
      chk("lit_both_cause", 32'(halt_cause), 32'd1);
      bp_en = 1'b0;

      // rst in the middle of a dump
      dump_ready = 1'b1;
      send(3'd4, 16'd0);
      n = 0;
      while (!(dump_valid === 1'b1 && dump_idx == 5'd5) && n < 20) begin
         tick();
         n++;
      end
      chk("dump_reach5", 32'(dump_idx), 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dump_ready = 1'b0;
      chk("lit_mid_dump_dv", 32'(dump_valid), 32'd0);
      chk("lit_mid_dump_rst", 32'(cpu_rst), 32'd1);
      wait_halted("mid_dump_halt", 20);
      chk("lit_mid_dump_cause", 32'(halt_cause), 32'd3);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mips_run_ctrl
`default_nettype wire

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Run-control sequencer for the single-cycle mips core.
- Gates instruction execution through a clock enable and drives the core reset.
- Supports halt/run/single-step with a PC breakpoint.
- Walks the debug register-read port to stream all 32 GPRs to the monitor.
- Sits between the monitor command interface and the core: drives the core's dbg_ra and rst, and gates its clock enable.

Parameters:
RST_CYCLES, 2, cycles core reset is held on a RESET command (>=1)
STEP_W, 16, width of step count argument
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  3  0=HALT 1=RUN 2=STEP 3=RESET 4=DUMP, 5-7 illegal
cmd_steps  in  STEP_W  instruction count for STEP; 0 treated as 1
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
pc  in  32  core PC
cpu_en  out  1  core clock enable; one instruction retires per high cycle
cpu_rst  out  1  core reset
dbg_ra  out  5  core debug register address
dbg_rd  in  32  core debug register data (combinational read)
dump_valid  out  1  dump word valid
dump_ready  in  1  monitor accepts dump word
dump_data  out  32  register value (= dbg_rd)
dump_idx  out  5  register index of dump_data
dump_last  out  1  dump_idx==31 while dump_valid
halted  out  1  state==HALT
halt_cause  out  2  0=command 1=breakpoint 2=step done 3=reset
instr_count  out  CNT_W  instructions retired, wraps
cmd_err  out  1  sticky: illegal or dropped command; cleared on accepted RESET

Behaviour:
- States: CRST, HALT, RUN, STEP, DUMP.
- rst: state=CRST, rst_cnt=RST_CYCLES-1, cpu_rst=1, cpu_en=0, dbg_ra=0, instr_count=0, halt_cause=3, cmd_err=0, dump_valid=0.
- CRST:
  - cpu_rst=1, cpu_en=0, cmd_ready=0.
  - Decrement rst_cnt; at 0 -> HALT next cycle with halt_cause=3.
  - Total reset assertion = RST_CYCLES cycles after the last rst/RESET accept.
- HALT:
  - cmd_ready=1, cpu_en=0.
  - RUN -> RUN; STEP -> STEP, step_cnt=max(cmd_steps,1); DUMP -> DUMP, dbg_ra=0.
  - RESET -> CRST, instr_count=0, cmd_err=0.
  - HALT: no-op. Illegal op: sets cmd_err.
- RUN:
  - cpu_en combinational = (state==RUN) & ~bp_hit.
  - bp_hit = bp_en & pc==bp_addr & ~first, where first = first cycle in RUN/STEP after leaving HALT, so the core can run off a breakpoint.
  - On bp_hit: cpu_en=0 that cycle (breakpoint instruction not executed) -> HALT, cause=1.
- STEP:
  - cpu_en=(state==STEP) & ~bp_hit. Each cpu_en cycle decrements step_cnt.
  - When the cycle with step_cnt==1 retires -> HALT, cause=2.
  - bp_hit -> HALT, cause=1; the breakpoint has priority over step completion.
- Commands in RUN/STEP:
  - cmd_ready=1.
  - HALT: cpu_en is still evaluated normally that cycle, then -> HALT, cause=0.
  - RESET: cpu_en=0 that cycle -> CRST.
  - Others: accepted and dropped, cmd_err=1.
  - Same-cycle HALT cmd and bp_hit: cause=1.
- DUMP:
  - cmd_ready=0, cpu_en=0, dump_valid=1, dump_idx=dbg_ra, dump_data=dbg_rd.
  - On valid&ready: dbg_ra++. After idx 31 is accepted -> HALT, dbg_ra=0, cause unchanged.
  - dump_valid/data held stable while ready=0.
- instr_count increments on every cpu_en=1 cycle and wraps modulo 2^CNT_W.
- rst mid-RUN/DUMP: immediate to CRST; in-progress dump is abandoned.
- Latency: command accepted in cycle N; new state, and cpu_en for RUN/STEP, first effective in cycle N+1.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - cmd_op encodings
  - halt_cause encodings
  - state enum
  - NUM_REGS=32
- No sub-module needed.
- The optional counter helper (rst_cnt/step_cnt) stays inline.

Test Plan:
- rst 1 cycle -> cpu_rst high exactly 2 cycles after release; halted=1, halt_cause=3, instr_count=0, cmd_err=0.
- STEP cmd_steps=3 from HALT -> exactly 3 cpu_en cycles; instr_count=3; halted with cause=2. cmd_steps=0 -> 1 cycle.
- RUN with bp_en=1, bp_addr=0x10, pc advancing 0,4,8,... -> cpu_en high for pc 0..0xC and low when pc=0x10; cause=1; instr_count=4. A following STEP 1 executes 0x10 (first-cycle bp masking).
- DUMP with dump_ready toggling 1,0,1,... -> 32 words in order idx 0..31 with data=dbg_rd; dump_last only on idx 31; data stable while ready=0; returns to HALT, cpu_en never high.
- During RUN, RESET cmd -> cpu_en 0 same cycle, cpu_rst for 2 cycles, instr_count=0. STEP cmd during RUN -> ignored, cmd_err=1, still running. cmd_op=6 in HALT -> cmd_err=1.
- HALT cmd and bp_hit in same cycle -> cause=1. rst asserted mid-DUMP at idx 5 -> dump_valid 0 next cycle, CRST entered.
